// File: rtl/scroll_move_pacer.sv
// Obstacle step pacer. A synchronized vsync frame tick drives a RUN/IDLE/HIT FSM that emits move strobes.
// It also tracks collisions and obstacle wrap-arounds. Define SCROLL_PACER_AUTOSPEED_EN to add automatic speed-up on every 8th wrap.
module scroll_move_pacer (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       enable,
  input  logic       speed_up,
  input  logic       clear_hit,
  input  logic [9:0] h_pos,
  input  logic [9:0] player_x,
  input  logic       player_in_lane,
  output logic       move,
  output logic [1:0] speed,
  output logic       hit,
  output logic [7:0] wrap_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_vs_meta;
  logic        r_vs_sync;
  logic        r_vs_prev;
  logic [1:0]  r_fcnt;
  logic [1:0]  r_term;
  logic        r_move;
  logic [1:0]  r_speed;
  logic [7:0]  r_wrap_cnt;
  logic [9:0]  r_h_prev;

  logic        w_tick;
  logic [10:0] w_player_right;
  logic [10:0] w_obst_right;
  logic        w_collide;
  logic        w_due;
  logic        w_wrap_inc;
  logic        w_auto_inc;
  logic        w_speed_inc;

  assign w_tick = r_vs_sync & ~r_vs_prev;

  // Edges widened to 11 bits so obstacles near x=1023 do not wrap to the left.
  assign w_player_right = {1'b0, player_x} + 11'd16;
  assign w_obst_right   = {1'b0, h_pos} + 11'd32;
  assign w_collide = (r_state == S_RUN) && player_in_lane &&
                     ({1'b0, h_pos} < w_player_right) &&
                     ({1'b0, player_x} < w_obst_right);

  assign w_due = (r_state == S_RUN) && w_tick && (r_fcnt == r_term);

  assign w_wrap_inc = (r_h_prev < 10'd16) && (h_pos == 10'd640) && (r_wrap_cnt != 8'hFF);

`ifdef SCROLL_PACER_AUTOSPEED_EN
  // The count is about to reach a multiple of 8 when its low bits are 7.
  assign w_auto_inc = w_wrap_inc && (r_wrap_cnt[2:0] == 3'd7);
`else
  assign w_auto_inc = 1'b0;
`endif

  assign w_speed_inc = speed_up | w_auto_inc;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (enable) w_next = S_RUN;
      S_RUN: begin
        if (w_collide)    w_next = S_HIT;
        else if (!enable) w_next = S_IDLE;
      end
      S_HIT:  if (clear_hit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_vs_meta  <= 1'b0;
      r_vs_sync  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_move     <= 1'b0;
      r_speed    <= 2'd0;
      r_wrap_cnt <= 8'd0;
      r_h_prev   <= 10'd0;
    end else begin
      r_state    <= w_next;
      r_vs_meta  <= vsync;
      r_vs_sync  <= r_vs_meta;
      r_vs_prev  <= r_vs_sync;
      r_move     <= w_due && (w_next == S_RUN);
      r_h_prev   <= h_pos;
      if (w_wrap_inc)                     r_wrap_cnt <= r_wrap_cnt + 8'd1;
      if (w_speed_inc && r_speed != 2'd3) r_speed    <= r_speed + 2'd1;
    end
  end

  // Terminal count is latched at each clear, so a speed change waits for the next period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fcnt <= 2'd0;
      r_term <= 2'd3;
    end else if (r_state != S_RUN) begin
      r_fcnt <= 2'd0;
      r_term <= 2'd3 - r_speed;
    end else if (w_tick) begin
      if (r_fcnt == r_term) begin
        r_fcnt <= 2'd0;
        r_term <= 2'd3 - r_speed;
      end else begin
        r_fcnt <= r_fcnt + 2'd1;
      end
    end
  end

  assign move     = r_move;
  assign speed    = r_speed;
  assign hit      = (r_state == S_HIT);
  assign wrap_cnt = r_wrap_cnt;

endmodule
